// File: rtl/ram_port_arb_if.sv
// ram_port_arb_if: two master request ports plus the shared single RAM port
interface ram_port_arb_if #(
    parameter int dat_width = 32,
    parameter int adr_width = 32
);
    logic                 m0_req;
    logic                 m0_we;
    logic [adr_width-1:0] m0_adr;
    logic [dat_width-1:0] m0_wdat;
    logic                 m0_lock;
    logic                 m0_ack;
    logic                 m0_resp;
    logic [dat_width-1:0] m0_rdat;
    logic                 m1_req;
    logic                 m1_we;
    logic [adr_width-1:0] m1_adr;
    logic [dat_width-1:0] m1_wdat;
    logic                 m1_lock;
    logic                 m1_ack;
    logic                 m1_resp;
    logic [dat_width-1:0] m1_rdat;
    logic [adr_width-1:0] ram_adr;
    logic [dat_width-1:0] ram_dat;
    logic                 ram_we;
    logic [dat_width-1:0] ram_rdat;

    modport slave (
        input  m0_req, m0_we, m0_adr, m0_wdat, m0_lock,
        input  m1_req, m1_we, m1_adr, m1_wdat, m1_lock,
        input  ram_rdat,
        output m0_ack, m0_resp, m0_rdat,
        output m1_ack, m1_resp, m1_rdat,
        output ram_adr, ram_dat, ram_we
    );

    modport master (
        output m0_req, m0_we, m0_adr, m0_wdat, m0_lock,
        output m1_req, m1_we, m1_adr, m1_wdat, m1_lock,
        output ram_rdat,
        input  m0_ack, m0_resp, m0_rdat,
        input  m1_ack, m1_resp, m1_rdat,
        input  ram_adr, ram_dat, ram_we
    );
endinterface

// File: rtl/ram_port_arb.sv
// ram_port_arb: shares one synchronous RAM port between two masters with round-robin or fixed priority (RAM_PORT_ARB_FIXED_PRIO_EN) and lock
module ram_port_arb (
    input logic          clk,
    input logic          rst,
    ram_port_arb_if.slave bus
);
    logic lock_vld;
    logic lock_own;
    logic rsp_vld;
    logic rsp_id;
    logic pick1;
    logic elig0;
    logic elig1;
    logic gnt0;
    logic gnt1;
    logic acc_lock;

`ifdef RAM_PORT_ARB_FIXED_PRIO_EN
    assign pick1 = 1'b0;
`else
    logic last;

    // round-robin pointer: remembers the last accepted master, m0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (gnt0 | gnt1)
            last <= gnt1;
    end

    assign pick1 = ~last;
`endif

    // eligibility under lock, then tie-break; nothing is granted while in reset
    always_comb begin
        elig0    = bus.m0_req & (~lock_vld | ~lock_own);
        elig1    = bus.m1_req & (~lock_vld | lock_own);
        gnt0     = ~rst & elig0 & (~elig1 | ~pick1);
        gnt1     = ~rst & elig1 & (~elig0 | pick1);
        acc_lock = gnt1 ? bus.m1_lock : bus.m0_lock;
    end

    // lock state and response tracking; only lock_own can be accepted while locked,
    // so any acceptance simply reloads lock_vld from that master's lock input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_own <= 1'b0;
            rsp_vld  <= 1'b0;
            rsp_id   <= 1'b0;
        end else begin
            rsp_vld <= gnt0 | gnt1;
            if (gnt0 | gnt1) begin
                rsp_id   <= gnt1;
                lock_vld <= acc_lock;
                if (acc_lock)
                    lock_own <= gnt1;
            end
        end
    end

    assign bus.m0_ack  = gnt0;
    assign bus.m1_ack  = gnt1;
    assign bus.ram_adr = gnt1 ? bus.m1_adr : bus.m0_adr;
    assign bus.ram_dat = gnt1 ? bus.m1_wdat : bus.m0_wdat;
    assign bus.ram_we  = gnt0 ? bus.m0_we : gnt1 ? bus.m1_we : 1'b0;
    assign bus.m0_resp = rsp_vld & ~rsp_id;
    assign bus.m1_resp = rsp_vld & rsp_id;
    assign bus.m0_rdat = bus.ram_rdat;
    assign bus.m1_rdat = bus.ram_rdat;
endmodule

// File: tb/tb_ram_port_arb.sv
// tb_ram_port_arb: scoreboard bench for ram_port_arb with a read-before-write RAM model
module tb_ram_port_arb;
    typedef struct {
        logic        id;
        logic [31:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    logic [31:0] mem [0:15];
    logic [31:0] exp_mem [0:15];
    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    logic m_last = 1'b1;
    logic m_lock_vld = 1'b0;
    logic m_lock_own = 1'b0;

    ram_port_arb_if #(.dat_width(32), .adr_width(32)) bus();

    ram_port_arb dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            mem[1] <= 32'h11;
            mem[2] <= 32'h22;
            mem[5] <= 32'hDEADBEEF;
            mem[9] <= 32'h0BAD0009;
        end else begin
            bus.ram_rdat <= mem[bus.ram_adr[3:0]];
            if (bus.ram_we)
                mem[bus.ram_adr[3:0]] <= bus.ram_dat;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_resp();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("m0_resp", bus.m0_resp, !e.id);
            chk("m1_resp", bus.m1_resp, e.id);
            chk("rdat", e.id ? bus.m1_rdat : bus.m0_rdat, e.dat);
        end else begin
            chk("m0_resp_idle", bus.m0_resp, 0);
            chk("m1_resp_idle", bus.m1_resp, 0);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = 1'b1;
        m_lock_vld = 1'b0;
        m_lock_own = 1'b0;
    endtask

    task automatic step(input logic r0, w0, l0, input logic [31:0] a0, d0,
                        input logic r1, w1, l1, input logic [31:0] a1, d1);
        exp_t e;
        logic e0, e1, p1, g0, g1, gw, gl;
        logic [31:0] ga, gd;
        @(negedge clk);
        check_resp();
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_lock = l0; bus.m0_adr = a0; bus.m0_wdat = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_lock = l1; bus.m1_adr = a1; bus.m1_wdat = d1;
        #1;
        e0 = r0 & (!m_lock_vld | !m_lock_own);
        e1 = r1 & (!m_lock_vld | m_lock_own);
`ifdef RAM_PORT_ARB_FIXED_PRIO_EN
        p1 = 1'b0;
`else
        p1 = !m_last;
`endif
        g0 = e0 & (!e1 | !p1);
        g1 = e1 & (!e0 | p1);
        gw = g1 ? w1 : w0;
        gl = g1 ? l1 : l0;
        ga = g1 ? a1 : a0;
        gd = g1 ? d1 : d0;
        chk("m0_ack", bus.m0_ack, g0);
        chk("m1_ack", bus.m1_ack, g1);
        chk("ram_we", bus.ram_we, (g0 | g1) & gw);
        if (g0 | g1) begin
            chk("ram_adr", bus.ram_adr, ga);
            if (gw)
                chk("ram_dat", bus.ram_dat, gd);
            e.id = g1;
            e.dat = exp_mem[ga[3:0]];
            q.push_back(e);
            if (gw)
                exp_mem[ga[3:0]] = gd;
            m_last = g1;
            m_lock_vld = gl;
            if (gl)
                m_lock_own = g1;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            exp_mem[i] = 32'h0;
        exp_mem[1] = 32'h11;
        exp_mem[2] = 32'h22;
        exp_mem[5] = 32'hDEADBEEF;
        exp_mem[9] = 32'h0BAD0009;
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_lock = 0; bus.m0_adr = 0; bus.m0_wdat = 0;
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_lock = 0; bus.m1_adr = 0; bus.m1_wdat = 0;
        repeat (3) @(negedge clk);
        chk("rst_m0_ack", bus.m0_ack, 0);
        chk("rst_m1_ack", bus.m1_ack, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_m0_resp", bus.m0_resp, 0);
        chk("rst_m1_resp", bus.m1_resp, 0);
        preload = 0;
        bus.m0_req = 0; bus.m1_req = 0;
        rst = 0;

        // single read
        step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        idle();

        // contention, both reading continuously
        for (int i = 0; i < 6; i++)
            step(1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
        idle();

        // write then read by m1
        step(0, 0, 0, 0, 0, 1, 1, 0, 9, 32'hA5A5A5A5);
        step(0, 0, 0, 0, 0, 1, 0, 0, 9, 0);
        idle();

        // lock held by m0 for three transactions, then released
        for (int i = 0; i < 3; i++)
            step(1, 0, 1, 1, 0, 1, 0, 0, 2, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
        idle();

        // reset right after a locked m0 read is accepted
        step(1, 0, 1, 5, 0, 1, 0, 0, 2, 0);
        @(posedge clk);
        #1;
        rst = 1;
        model_reset();
        #1;
        chk("mid_rst_m0_resp", bus.m0_resp, 0);
        chk("mid_rst_m1_resp", bus.m1_resp, 0);
        chk("mid_rst_m0_ack", bus.m0_ack, 0);
        chk("mid_rst_m1_ack", bus.m1_ack, 0);
        chk("mid_rst_ram_we", bus.ram_we, 0);
        repeat (2) begin
            @(negedge clk);
            chk("in_rst_m0_resp", bus.m0_resp, 0);
            chk("in_rst_m0_ack", bus.m0_ack, 0);
            chk("in_rst_m1_ack", bus.m1_ack, 0);
        end
        bus.m0_req = 0; bus.m1_req = 0;
        rst = 0;
        step(0, 0, 0, 0, 0, 1, 0, 0, 2, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0, 2, 0);

        // idle period
        repeat (10) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_port_arb.md
# ram_port_arb

Two-requester arbiter that shares a single synchronous port of the team's dual-port block RAM between two masters, e.g. the instruction-fetch and data units of a core when only one RAM port is free. It grants at most one transaction per cycle, drives the RAM port address, data and write enable, and routes the one-cycle-later RAM read data back to the granted master with a response pulse. Round-robin fairness is the default. An optional lock keeps the grant on one master for atomic sequences.

## Interface
- dat_width, 32, data width of masters and RAM port
- adr_width, 32, address width of masters and RAM port (word address, passed through unchanged)
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req_i / m1_req_i  in  1  transaction request
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read
- m0_adr_i / m1_adr_i  in  adr_width  word address
- m0_wdat_i / m1_wdat_i  in  dat_width  write data
- m0_lock_i / m1_lock_i  in  1  keep grant after this transaction
- m0_ack_o / m1_ack_o  out  1  combinational grant; transaction accepted when req & ack
- m0_resp_o / m1_resp_o  out  1  one-cycle pulse, transaction completed
- m0_rdat_o / m1_rdat_o  out  dat_width  read data, valid while resp high
- ram_adr_o  out  adr_width  to RAM adr_i
- ram_dat_o  out  dat_width  to RAM dat_i
- ram_we_o  out  1  to RAM we_i
- ram_dat_i  in  dat_width  from RAM dat_o (registered, 1-cycle read latency)

## Operation
- Grant logic is combinational from req inputs, the priority pointer and the lock state. Exactly one or zero acks are high per cycle.
- Priority pointer `last`: 1 bit, holds the index of the last accepted master. If both masters request, the master that is not `last` wins. If only one master requests, that master wins. `last` updates on every accepted transaction.
- Lock:
  - `lock_vld` is set and `lock_own` is set to the accepting master when that master is accepted with lock_i=1.
  - While lock_vld is set, only lock_own can be acked. The other master's req is held off indefinitely.
  - lock_vld is cleared when lock_own is accepted with lock_i=0.
- RAM drive:
  - When a master is granted: ram_adr_o = its adr, ram_dat_o = its wdat, ram_we_o = its we.
  - With no grant: ram_we_o = 0, and ram_adr_o/ram_dat_o carry master 0's values (don't care).
- Response tracking: the registers `rsp_vld` and `rsp_id` capture the acceptance and the granted index. The cycle after acceptance, mX_resp_o = rsp_vld & (rsp_id==X).
- Read data:
  - mX_rdat_o = ram_dat_i for both masters. It is only meaningful while the matching resp is high.
  - A write also produces a resp pulse. Its rdat is the pre-write contents (read-before-write RAM).
- No backpressure on responses: masters must accept the resp cycle.

## Timing
- Reset values: last=1 (m0 wins first contention), lock_vld=0, lock_own=0, rsp_vld=0, rsp_id=0. All resp outputs are 0.
  - While rst is high, all acks are forced to 0 and ram_we_o=0.
  - Reset mid-lock or mid-response clears the lock and drops the pending resp.
- Throughput: one transaction per cycle, back-to-back, with no bubbles.
- Latency: accept in cycle N, resp/rdat in cycle N+1.
- Contention example: both masters request every cycle with no lock → grants alternate m0, m1, m0, …
- A master may change adr/we/wdat only after its ack cycle. Inputs are sampled only in the ack cycle.
- Same-cycle lock release by lock_own: the other master may be granted in the very next cycle.

## Configuration
- RAM_PORT_ARB_FIXED_PRIO_EN
  - Defined: m0 always wins contention. `last` is not used for the decision (it may be left unimplemented). The lock still applies.
  - Undefined: round-robin as described above.

## Test plan
- Single read: preload word 5 = 32'hDEADBEEF. m0 reads adr 5 → m0_ack same cycle; next cycle m0_resp=1, m0_rdat=32'hDEADBEEF, m1_resp=0.
- Contention: m0 and m1 both read continuously at adr 1/2 (contents 32'h11/32'h22) → acks alternate m0, m1, m0; resps alternate one cycle later with the matching data. Under RAM_PORT_ARB_FIXED_PRIO_EN, m0 gets every ack and m1 none.
- Write-then-read: m1 writes 32'hA5A5A5A5 to adr 9, then reads adr 9 → the second resp returns 32'hA5A5A5A5, and the first resp returns the old contents.
- Lock: m0 accepted with lock=1 for 3 transactions, then lock=0, while m1 requests throughout → m1_ack=0 for all 4 cycles; m1 is acked in the cycle after m0's lock=0 transaction.
- Reset mid-operation: assert rst in the cycle after an m0 read is accepted with lock=1 → m0_resp stays 0, acks stay 0 during reset; after release, m1 is acked immediately on request (lock cleared, last=1 so m0 wins a tie).
- Idle: no requests for 10 cycles → ram_we_o=0, all acks and resps 0.
